// File: rtl/flag_ctrl.sv
// flag_ctrl: round-robin arbiter for the flagstore write port plus save/restore LIFO.
// The save/restore stack is built only when FLAG_CTRL_STACK_EN is defined.
module flag_ctrl #(
  parameter int NREQ  = 2,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         nrst,
  input  logic [0:NREQ-1]              req_valid,
  input  logic [0:4*NREQ-1]            req_mask,
  input  logic [0:4*NREQ-1]            req_flags,
  output logic [0:NREQ-1]              req_ready,
  input  logic                         save,
  input  logic                         restore,
  input  logic [0:3]                   cur_flags,
  output logic [0:3]                   flag_mask,
  output logic [0:3]                   new_flags,
  output logic [$clog2(DEPTH+1)-1:0]   stack_count,
  output logic                         stack_full,
  output logic                         stack_empty,
  output logic                         stack_err
);
  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(DEPTH+1);
  logic [PW-1:0]   rr_q, rr_d, idx;
  logic            found, do_restore;
  logic [0:3]      top, msk, flg;
  logic [0:NREQ-1] rdy;
  always_comb begin
    rdy   = '0;
    msk   = '0;
    flg   = '0;
    rr_d  = rr_q;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = PW'((int'(rr_q) + k) % NREQ);
      if (!found && req_valid[idx]) begin
        found    = 1'b1;
        rdy[idx] = 1'b1;
        msk      = req_mask[4*idx +: 4];
        flg      = req_flags[4*idx +: 4];
        rr_d     = PW'((int'(idx) + 1) % NREQ);
      end
    end
    if (do_restore) begin
      rdy  = '0;
      msk  = 4'b1111;
      flg  = top;
      rr_d = rr_q;
    end
  end
  assign req_ready = nrst ? rdy : '0;
  assign flag_mask = nrst ? msk : '0;
  assign new_flags = nrst ? flg : '0;
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) rr_q <= '0;
    else       rr_q <= rr_d;
`ifdef FLAG_CTRL_STACK_EN
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  logic [0:3]    stk_q [DEPTH];
  logic [0:3]    stk_d [DEPTH];
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d, full, empty;
  logic [AW-1:0] top_i;
  assign empty      = (cnt_q == '0);
  assign full       = (cnt_q == CW'(DEPTH));
  assign top_i      = AW'(cnt_q - 1'b1);
  assign top        = stk_q[top_i];
  assign do_restore = restore && !empty;
  always_comb begin
    stk_d = stk_q;
    cnt_d = cnt_q;
    err_d = err_q;
    if (do_restore && save) stk_d[top_i] = cur_flags;
    else if (do_restore) cnt_d = cnt_q - 1'b1;
    else begin
      // here restore can only mean underflow; a full save is dropped
      err_d = err_q | restore | (save & full);
      if (save && !full) begin
        stk_d[AW'(cnt_q)] = cur_flags;
        cnt_d = cnt_q + 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  always_ff @(posedge clk) stk_q <= stk_d;
  assign stack_count = cnt_q;
  assign stack_full  = full;
  assign stack_empty = empty;
  assign stack_err   = err_q;
`else
  logic unused_stack;
  assign unused_stack = ^{save, restore, cur_flags};
  assign do_restore   = 1'b0;
  assign top          = '0;
  assign stack_count  = '0;
  assign stack_full   = 1'b0;
  assign stack_empty  = 1'b1;
  assign stack_err    = 1'b0;
`endif
endmodule

// File: tb/tb_flag_ctrl.sv
// tb_flag_ctrl: vector table, directed stack sequences and random traffic against a queue model.
module tb_flag_ctrl;
  localparam int NREQ  = 2;
  localparam int DEPTH = 4;
`ifdef FLAG_CTRL_STACK_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif
  logic                clk, nrst, save, restore;
  logic [0:NREQ-1]     req_valid, req_ready;
  logic [0:4*NREQ-1]   req_mask, req_flags;
  logic [0:3]          cur_flags, flag_mask, new_flags;
  logic [2:0]          stack_count;
  logic                stack_full, stack_empty, stack_err;

  flag_ctrl #(.NREQ(NREQ), .DEPTH(DEPTH)) dut (
    .clk(clk), .nrst(nrst), .req_valid(req_valid), .req_mask(req_mask),
    .req_flags(req_flags), .req_ready(req_ready), .save(save), .restore(restore),
    .cur_flags(cur_flags), .flag_mask(flag_mask), .new_flags(new_flags),
    .stack_count(stack_count), .stack_full(stack_full), .stack_empty(stack_empty),
    .stack_err(stack_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int m_rr;
  logic [0:3] m_q[$];
  bit m_err;

  typedef struct {
    logic [0:1] v;
    logic [0:7] m, f;
    logic [0:1] er;
    logic [0:3] em, ef;
  } vec_t;
  vec_t tbl[10];

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask

  task automatic model_reset();
    m_rr = 0;
    m_q.delete();
    m_err = 1'b0;
  endtask

  task automatic model_out(output logic [0:NREQ-1] r, output logic [0:3] m, output logic [0:3] f);
    r = '0; m = '0; f = '0;
    if (EN && restore && m_q.size() > 0) begin
      m = 4'b1111;
      f = m_q[m_q.size()-1];
    end else
      for (int k = 0; k < NREQ; k++) begin
        int i = (m_rr + k) % NREQ;
        if (req_valid[i]) begin
          r[i] = 1'b1;
          m = req_mask[4*i +: 4];
          f = req_flags[4*i +: 4];
          break;
        end
      end
  endtask

  task automatic model_edge();
    bit forced = EN && restore && m_q.size() > 0;
    if (!forced)
      for (int k = 0; k < NREQ; k++) begin
        int i = (m_rr + k) % NREQ;
        if (req_valid[i]) begin
          m_rr = (i + 1) % NREQ;
          break;
        end
      end
    if (EN) begin
      if (forced && save) m_q[m_q.size()-1] = cur_flags;
      else if (forced) void'(m_q.pop_back());
      else begin
        if (restore) m_err = 1'b1;
        if (save) begin
          if (m_q.size() == DEPTH) m_err = 1'b1;
          else m_q.push_back(cur_flags);
        end
      end
    end
  endtask

  task automatic chk_state(input string nm);
    chk({nm, "_count"}, stack_count, m_q.size());
    chk({nm, "_full"},  stack_full,  m_q.size() == DEPTH);
    chk({nm, "_empty"}, stack_empty, m_q.size() == 0);
    chk({nm, "_err"},   stack_err,   m_err);
  endtask

  task automatic set_in(input logic [0:NREQ-1] v, input logic [0:4*NREQ-1] m, input logic [0:4*NREQ-1] f,
                        input logic s, input logic r, input logic [0:3] c);
    req_valid = v; req_mask = m; req_flags = f; save = s; restore = r; cur_flags = c;
  endtask

  task automatic apply(input string nm, input logic [0:NREQ-1] er, input logic [0:3] em, input logic [0:3] ef);
    #3;
    chk({nm, "_ready"}, req_ready, er);
    chk({nm, "_mask"},  flag_mask, em);
    chk({nm, "_flags"}, new_flags, ef);
    chk_state(nm);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic step(input string nm);
    logic [0:NREQ-1] er;
    logic [0:3] em, ef;
    model_out(er, em, ef);
    apply(nm, er, em, ef);
  endtask

  task automatic do_reset();
    set_in(2'b11, 8'hff, 8'hff, 1'b1, 1'b1, 4'b1010);
    #2 nrst = 1'b0;
    model_reset();
    #1;
    chk("rst_ready", req_ready, 0);
    chk("rst_mask",  flag_mask, 0);
    chk("rst_flags", new_flags, 0);
    chk_state("rst");
    @(posedge clk);
    #1 nrst = 1'b1;
    set_in(2'b00, 8'h00, 8'h00, 1'b0, 1'b0, 4'b0000);
  endtask

  initial begin
    tbl[0] = '{2'b11, 8'b1111_0001, 8'b0101_0011, 2'b10, 4'b1111, 4'b0101};
    tbl[1] = '{2'b11, 8'b1111_0001, 8'b0101_0011, 2'b01, 4'b0001, 4'b0011};
    tbl[2] = '{2'b11, 8'b1111_0001, 8'b0101_0011, 2'b10, 4'b1111, 4'b0101};
    tbl[3] = '{2'b11, 8'b1111_0001, 8'b0101_0011, 2'b01, 4'b0001, 4'b0011};
    tbl[4] = '{2'b01, 8'b0000_1010, 8'b0000_1000, 2'b01, 4'b1010, 4'b1000};
    tbl[5] = '{2'b00, 8'b1111_1111, 8'b1111_1111, 2'b00, 4'b0000, 4'b0000};
    tbl[6] = '{2'b10, 8'b0000_0000, 8'b1111_0000, 2'b10, 4'b0000, 4'b1111};
    tbl[7] = '{2'b01, 8'b0000_0110, 8'b0000_0100, 2'b01, 4'b0110, 4'b0100};
    tbl[8] = '{2'b10, 8'b0011_0000, 8'b0010_0000, 2'b10, 4'b0011, 4'b0010};
    tbl[9] = '{2'b11, 8'b1000_0100, 8'b1000_0000, 2'b01, 4'b0100, 4'b0000};
    nrst = 1'b0;
    model_reset();
    set_in(2'b11, 8'hff, 8'hff, 1'b0, 1'b0, 4'b0000);
    #2;
    chk("init_ready", req_ready, 0);
    chk("init_mask",  flag_mask, 0);
    chk_state("init");
    @(posedge clk);
    #1 nrst = 1'b1;

    for (int i = 0; i < 10; i++) begin
      set_in(tbl[i].v, tbl[i].m, tbl[i].f, 1'b0, 1'b0, 4'($urandom));
      apply($sformatf("vec%0d", i), tbl[i].er, tbl[i].em, tbl[i].ef);
    end

    set_in(2'b00, 8'h00, 8'h00, 1'b1, 1'b0, 4'b0110);
    step("save1");
    chk("save1_cnt", stack_count, EN ? 1 : 0);
    set_in(2'b10, 8'b0011_0000, 8'b0101_0000, 1'b0, 1'b1, 4'b0001);
    apply("rest1", EN ? 2'b00 : 2'b10, EN ? 4'b1111 : 4'b0011, EN ? 4'b0110 : 4'b0101);
    chk("rest1_cnt", stack_count, 0);

    do_reset();
    for (int i = 1; i <= 5; i++) begin
      set_in(2'b00, 8'h00, 8'h00, 1'b1, 1'b0, 4'(i));
      step($sformatf("ovf%0d", i));
    end
    chk("ovf_cnt",  stack_count, EN ? 4 : 0);
    chk("ovf_full", stack_full, EN);
    chk("ovf_err",  stack_err, EN);
    set_in(2'b00, 8'h00, 8'h00, 1'b0, 1'b1, 4'b0000);
    apply("ovf_pop", 2'b00, EN ? 4'b1111 : 4'b0000, EN ? 4'd4 : 4'd0);
    chk("ovf_pop_cnt", stack_count, EN ? 3 : 0);

    do_reset();
    set_in(2'b00, 8'h00, 8'h00, 1'b0, 1'b1, 4'b1111);
    apply("unf", 2'b00, 4'b0000, 4'b0000);
    chk("unf_err", stack_err, EN);
    set_in(2'b01, 8'b0000_1100, 8'b0000_0100, 1'b0, 1'b1, 4'b0000);
    apply("unf_arb", 2'b01, 4'b1100, 4'b0100);

    do_reset();
    set_in(2'b00, 8'h00, 8'h00, 1'b1, 1'b0, 4'b1100);
    step("xch_push");
    set_in(2'b00, 8'h00, 8'h00, 1'b1, 1'b1, 4'b0011);
    apply("xch", 2'b00, EN ? 4'b1111 : 4'b0000, EN ? 4'b1100 : 4'b0000);
    chk("xch_cnt", stack_count, EN ? 1 : 0);
    chk("xch_err", stack_err, 0);
    set_in(2'b00, 8'h00, 8'h00, 1'b0, 1'b1, 4'b0000);
    apply("xch_pop", 2'b00, EN ? 4'b1111 : 4'b0000, EN ? 4'b0011 : 4'b0000);
    chk("xch_pop_cnt", stack_count, 0);

    do_reset();
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset();
      set_in(NREQ'($urandom), 8'($urandom), 8'($urandom), ($urandom % 3) == 0,
             ($urandom % 3) == 0, 4'($urandom));
      step("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/flag_ctrl.md
# flag_ctrl

Arbiter and save/restore sequencer in front of `flagstore`. It shares the single flag-write port (`flag_mask`/`new_flags`) between NREQ requesters, such as the ALU, compare unit and control path, using round-robin priority. It also keeps a small LIFO of saved flag words for interrupt and call entry/exit, with restore taking priority over normal writes. The outputs drive `flagstore` directly; `cur_flags` is fed back from `flagstore` ({eq,lt,cf,of}).

## Interface
- NREQ, 2, number of flag-write requesters (2..8)
- DEPTH, 4, save-stack entries (1..16)
- clk  in  1  system clock, all state updates on posedge
- nrst  in  1  reset; asynchronous, active-low
- req_valid  in  [0:NREQ-1]  requester i wants a flag write this cycle
- req_mask  in  [0:4*NREQ-1]  requester i mask at bits 4i..4i+3 (eq,lt,cf,of order)
- req_flags  in  [0:4*NREQ-1]  requester i new flag values, same packing
- req_ready  out  [0:NREQ-1]  one-hot grant; write of granted requester commits at this edge
- save  in  1  push cur_flags onto stack
- restore  in  1  pop stack top into flagstore (all four flags)
- cur_flags  in  [0:3]  current flagstore contents
- flag_mask  out  [0:3]  to flagstore
- new_flags  out  [0:3]  to flagstore
- stack_count  out  $clog2(DEPTH+1)  entries held
- stack_full  out  1  stack_count == DEPTH
- stack_empty  out  1  stack_count == 0
- stack_err  out  1  sticky overflow/underflow flag; cleared only by reset

## Operation
- Port outputs (`req_ready`, `flag_mask`, `new_flags`) are combinational from inputs and state. State (`rr_ptr`, stack, count, err) is registered.
- Restore cycle (restore=1, stack non-empty):
  - flag_mask=4'b1111, new_flags=stack top.
  - All req_ready=0 and rr_ptr is held.
  - Pop at edge.
- Restore with stack empty:
  - Underflow: stack_err←1 at edge.
  - No flag write from the stack; arbitration proceeds as if restore=0.
- Normal cycle:
  - Search starts at rr_ptr and moves upward, wrapping mod NREQ.
  - The first valid requester i gets req_ready[i]=1, flag_mask=req_mask[i], new_flags=req_flags[i].
  - At the edge, rr_ptr←(i+1) mod NREQ.
  - A valid request with mask 0 is still granted and still advances rr_ptr.
- No valid request and no restore: flag_mask=0, new_flags=0, rr_ptr held.
- Save (not full): push cur_flags, which is the pre-edge value, so a write committing at the same edge is not included.
- Save when full: push dropped, stack_err←1, contents unchanged.
- save and restore together with stack non-empty: exchange.
  - Top←cur_flags and flagstore←old top.
  - count is unchanged, no error.
- save and restore together with stack empty: treated as underflow plus a normal save. Push happens, stack_err←1.
- Reset (nrst low, any time, asynchronous):
  - rr_ptr=0, stack_count=0, stack_err=0.
  - While nrst is low, flag_mask=0, new_flags=0, req_ready=0, regardless of inputs.
  - Stack entry contents are don't-care.

## Timing
- Grant-to-commit latency 0: req_ready and the flag write are both valid in the same cycle, and flagstore updates at the closing edge.
- A requester holds valid/mask/flags until it sees req_ready=1 at an edge. A requester may drop valid at any time before it is granted.
- Fairness: with all NREQ requesters continuously valid and no restore, each is granted exactly once per NREQ cycles.
- cur_flags shows a restore or write one cycle after its edge; a save on the next cycle sees the new value.
- stack_full, stack_empty and stack_count update at the edge of a push or pop.
- Reset deassertion is synchronised externally; first arbitration is on the first edge after release.

## Configuration
- FLAG_CTRL_STACK_EN defined: save/restore stack built as described above.
- FLAG_CTRL_STACK_EN undefined:
  - No stack storage is built, and save and restore are ignored.
  - stack_count=0, stack_empty=1, stack_full=0, stack_err=0 permanently.
  - Only round-robin arbitration remains.

## Test plan
- Reset: nrst=0 with req_valid=2'b11 → req_ready=0, flag_mask=0. After release, both valid → grants alternate 0,1,0,1 starting with req 0.
- Single requester: req1 mask=4'b1010, flags=4'b1000, cur_flags=4'b0000 → req_ready=2'b01, flag_mask=4'b1010, new_flags=4'b1000; rr_ptr←0.
- Save/restore:
  - cur_flags=4'b0110, save → count=1.
  - Then cur_flags=4'b0001, restore with req0 valid → flag_mask=4'b1111, new_flags=4'b0110, req_ready=0, count=0.
- Overflow/underflow (DEPTH=4):
  - 5 saves → count=4, full=1, stack_err=1, top = 4th pushed value.
  - After reset, restore on empty → stack_err=1, no forced write.
- Exchange: stack top=4'b1100, cur_flags=4'b0011, save+restore → new_flags=4'b1100, mask=4'b1111, count unchanged, next restore yields 4'b0011.
- Macro off: save/restore pulses → stack_empty stays 1, flag_mask reflects only requester grants.
